// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives loads/stores over a req/ack data-memory handshake and stalls
// upstream until completion. Optional WAIT timeout/abort is enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
    parameter int unsigned DSIZE       = 16,
    parameter int unsigned ASIZE       = 4,
    parameter int unsigned MAW         = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic [DSIZE-1:0] aluout_in,
    input  logic [DSIZE-1:0] store_data_in,
    input  logic [ASIZE-1:0] waddr_in,
    input  logic             write_en_in,
    input  logic             mem_to_reg_in,
    output logic             stall_out,
    output logic [DSIZE-1:0] mem_data_out,
    output logic [DSIZE-1:0] aluout_out,
    output logic [ASIZE-1:0] waddr_out,
    output logic             write_en_out,
    output logic             mem_to_reg_out,
    output logic             mem_err_out,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [MAW-1:0]   dmem_addr,
    output logic [DSIZE-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic [DSIZE-1:0] dmem_rdata
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [MAW-1:0]   addr_q, addr_d;
    logic [DSIZE-1:0] wdata_q, wdata_d;
    logic [DSIZE-1:0] aluout_q, aluout_d;
    logic [ASIZE-1:0] waddr_q, waddr_d;
    logic             wen_q, wen_d;
    logic             m2r_q, m2r_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic             mem_op;

    assign mem_op     = in_valid & (mem_read_in | mem_write_in);
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    assign mem_err_out = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign mem_err_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            aluout_q <= '0;
            waddr_q  <= '0;
            wen_q    <= 1'b0;
            m2r_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            aluout_q <= aluout_d;
            waddr_q  <= waddr_d;
            wen_q    <= wen_d;
            m2r_q    <= m2r_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        aluout_d = aluout_q;
        waddr_d  = waddr_q;
        wen_d    = wen_q;
        m2r_d    = m2r_q;
        rdata_d  = rdata_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (mem_op) begin
                    req_d    = 1'b1;
                    we_d     = mem_write_in;
                    addr_d   = aluout_in[MAW-1:0];
                    wdata_d  = store_data_in;
                    aluout_d = aluout_in;
                    waddr_d  = waddr_in;
                    wen_d    = write_en_in;
                    m2r_d    = mem_to_reg_in;
                    state_d  = StWait;
`ifdef MEM_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            StWait: begin
                // Ack has priority over a timeout on the same edge.
                if (dmem_ack) begin
                    rdata_d = dmem_rdata;
                    req_d   = 1'b0;
                    state_d = StDone;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CntLast) begin
                    rdata_d = '1;
                    wen_d   = 1'b0;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall_out      = 1'b0;
        mem_data_out   = '0;
        aluout_out     = aluout_in;
        waddr_out      = waddr_in;
        write_en_out   = in_valid & write_en_in;
        mem_to_reg_out = mem_to_reg_in;
        unique case (state_q)
            StIdle: begin
                if (mem_op) begin
                    stall_out    = 1'b1;
                    write_en_out = 1'b0;
                end
            end
            StWait: begin
                stall_out      = 1'b1;
                write_en_out   = 1'b0;
                aluout_out     = aluout_q;
                waddr_out      = waddr_q;
                mem_to_reg_out = m2r_q;
            end
            StDone: begin
                mem_data_out   = rdata_q;
                aluout_out     = aluout_q;
                waddr_out      = waddr_q;
                write_en_out   = wen_q;
                mem_to_reg_out = m2r_q;
            end
            default: ;
        endcase
        if (rst) begin
            stall_out    = 1'b0;
            write_en_out = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage: ALU pass-through, loads, stores,
// back-to-back ops, reset during WAIT and (with MEM_TIMEOUT_EN) the timeout abort.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, mem_read_in, mem_write_in;
    logic [15:0] aluout_in, store_data_in;
    logic [3:0]  waddr_in;
    logic        write_en_in, mem_to_reg_in;
    logic        stall_out;
    logic [15:0] mem_data_out, aluout_out;
    logic [3:0]  waddr_out;
    logic        write_en_out, mem_to_reg_out, mem_err_out;
    logic        dmem_req, dmem_we;
    logic [7:0]  dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DSIZE(16), .ASIZE(4), .MAW(8), .TIMEOUT_CYC(64)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .aluout_in(aluout_in), .store_data_in(store_data_in), .waddr_in(waddr_in),
        .write_en_in(write_en_in), .mem_to_reg_in(mem_to_reg_in),
        .stall_out(stall_out), .mem_data_out(mem_data_out), .aluout_out(aluout_out),
        .waddr_out(waddr_out), .write_en_out(write_en_out), .mem_to_reg_out(mem_to_reg_out),
        .mem_err_out(mem_err_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input logic v, input logic rd, input logic wr, input logic [15:0] alu,
                          input logic [15:0] sd, input logic [3:0] wa, input logic we,
                          input logic m2r);
        in_valid      = v;
        mem_read_in   = rd;
        mem_write_in  = wr;
        aluout_in     = alu;
        store_data_in = sd;
        waddr_in      = wa;
        write_en_in   = we;
        mem_to_reg_in = m2r;
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 16'h0;
        set_op(0, 0, 0, 16'h0, 16'h0, 4'h0, 0, 0);
        cyc();
        cyc();
        // Reset: a valid load presented during reset must neither stall nor write back.
        set_op(1, 1, 0, 16'h0055, 16'h0, 4'h1, 1, 0);
        check("rst_stall", stall_out, 0);
        check("rst_wen", write_en_out, 0);
        check("rst_req", dmem_req, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_err", mem_err_out, 0);
        cyc();

        // ALU op: zero-cycle pass-through
        rst = 1'b0;
        set_op(1, 0, 0, 16'h1234, 16'h0, 4'h3, 1, 0);
        check("alu_out", aluout_out, 32'h1234);
        check("alu_wen", write_en_out, 1);
        check("alu_stall", stall_out, 0);
        check("alu_waddr", waddr_out, 3);
        check("alu_mdata", mem_data_out, 0);
        cyc();

        // Load with 3-cycle ack delay
        set_op(1, 1, 0, 16'h0020, 16'h0, 4'h5, 1, 1);
        check("ld1_c0_stall", stall_out, 1);
        check("ld1_c0_wen", write_en_out, 0);
        check("ld1_c0_req", dmem_req, 0);
        cyc();
        check("ld1_c1_req", dmem_req, 1);
        check("ld1_c1_addr", dmem_addr, 32'h20);
        check("ld1_c1_we", dmem_we, 0);
        check("ld1_c1_stall", stall_out, 1);
        cyc();
        check("ld1_c2_req", dmem_req, 1);
        check("ld1_c2_addr", dmem_addr, 32'h20);
        check("ld1_c2_stall", stall_out, 1);
        cyc();
        check("ld1_c3_req", dmem_req, 1);
        check("ld1_c3_stall", stall_out, 1);
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hBEEF;
        cyc();
        dmem_ack = 1'b0;
        #1;
        check("ld1_done_req", dmem_req, 0);
        check("ld1_done_stall", stall_out, 0);
        check("ld1_done_data", mem_data_out, 32'hBEEF);
        check("ld1_done_m2r", mem_to_reg_out, 1);
        check("ld1_done_wen", write_en_out, 1);
        check("ld1_done_waddr", waddr_out, 5);
        check("ld1_done_alu", aluout_out, 32'h0020);
        check("ld1_done_err", mem_err_out, 0);
        cyc();

        // Second load accepted in the IDLE cycle right after DONE; ack in the request cycle
        set_op(1, 1, 0, 16'h0041, 16'h0, 4'h6, 1, 1);
        check("ld2_c0_req", dmem_req, 0);
        check("ld2_c0_stall", stall_out, 1);
        check("ld2_c0_wen", write_en_out, 0);
        cyc();
        check("ld2_c1_req", dmem_req, 1);
        check("ld2_c1_addr", dmem_addr, 32'h41);
        dmem_ack   = 1'b1;
        dmem_rdata = 16'h1357;
        cyc();
        dmem_ack = 1'b0;
        #1;
        check("ld2_done_data", mem_data_out, 32'h1357);
        check("ld2_done_wen", write_en_out, 1);
        check("ld2_done_waddr", waddr_out, 6);
        check("ld2_done_stall", stall_out, 0);
        cyc();

        // Store with ack in the same cycle as the request
        set_op(1, 0, 1, 16'h0077, 16'hA5A5, 4'h2, 0, 0);
        check("st_c0_stall", stall_out, 1);
        check("st_c0_req", dmem_req, 0);
        cyc();
        check("st_c1_req", dmem_req, 1);
        check("st_c1_we", dmem_we, 1);
        check("st_c1_addr", dmem_addr, 32'h77);
        check("st_c1_wdata", dmem_wdata, 32'hA5A5);
        dmem_ack = 1'b1;
        cyc();
        dmem_ack = 1'b0;
        #1;
        check("st_done_wen", write_en_out, 0);
        check("st_done_stall", stall_out, 0);
        check("st_done_req", dmem_req, 0);
        cyc();

        // Bubble with a stray ack in IDLE: must be ignored
        set_op(0, 0, 0, 16'h0099, 16'h0, 4'h9, 1, 0);
        dmem_ack = 1'b1;
        #1;
        check("idle_bubble_wen", write_en_out, 0);
        check("idle_bubble_stall", stall_out, 0);
        cyc();
        dmem_ack = 1'b0;
        #1;
        check("idle_ack_req", dmem_req, 0);
        check("idle_ack_stall", stall_out, 0);

        // Reset asserted while in WAIT drops the access
        set_op(1, 1, 0, 16'h0010, 16'h0, 4'h7, 1, 1);
        cyc();
        check("rw_c1_req", dmem_req, 1);
        rst = 1'b1;
        #1;
        check("rw_rst_stall", stall_out, 0);
        check("rw_rst_wen", write_en_out, 0);
        cyc();
        rst      = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 16'hDEAD;
        set_op(0, 0, 0, 16'h0, 16'h0, 4'h0, 0, 0);
        check("rw_after_req", dmem_req, 0);
        check("rw_after_stall", stall_out, 0);
        check("rw_after_wen", write_en_out, 0);
        cyc();
        dmem_ack = 1'b0;
        #1;
        check("rw_late_req", dmem_req, 0);
        check("rw_late_stall", stall_out, 0);
        check("rw_late_wen", write_en_out, 0);
        check("rw_late_data", mem_data_out, 0);
        cyc();

`ifdef MEM_TIMEOUT_EN
        begin
            int req_cycles = 0;
            set_op(1, 1, 0, 16'h0030, 16'h0, 4'h8, 1, 1);
            cyc();
            // Bounded: at most 64 WAIT cycles expected before DONE
            for (int i = 0; i < 64; i++) begin
                if (dmem_req && stall_out) req_cycles++;
                cyc();
            end
            check("to_wait_cycles", req_cycles, 64);
            check("to_done_err", mem_err_out, 1);
            check("to_done_data", mem_data_out, 32'hFFFF);
            check("to_done_wen", write_en_out, 0);
            check("to_done_stall", stall_out, 0);
            check("to_done_req", dmem_req, 0);
            set_op(0, 0, 0, 16'h0, 16'h0, 4'h0, 0, 0);
            cyc();
            check("to_after_err", mem_err_out, 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
